// File: rtl/writeback_regfile.sv
// Y86-64 write-back stage: W pipeline register, 15-entry architectural register file,
// two combinational decode read ports, sticky halt flag and retired-instruction counter.
module writeback_regfile #(
    parameter int               XLEN     = 64,
    parameter int               CNT_W    = 32,
    parameter logic [XLEN-1:0]  RSP_INIT = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             w_stall,
    input  logic             w_bubble,
    input  logic [1:0]       m_stat,
    input  logic [3:0]       m_icode,
    input  logic [XLEN-1:0]  m_valE,
    input  logic [XLEN-1:0]  m_valM,
    input  logic [3:0]       m_dstE,
    input  logic [3:0]       m_dstM,
    input  logic [3:0]       srcA,
    input  logic [3:0]       srcB,
    output logic [XLEN-1:0]  rvalA,
    output logic [XLEN-1:0]  rvalB,
    output logic [1:0]       W_stat,
    output logic [3:0]       W_icode,
    output logic [3:0]       W_dstE,
    output logic [3:0]       W_dstM,
    output logic [XLEN-1:0]  W_valE,
    output logic [XLEN-1:0]  W_valM,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    localparam logic [1:0] STAT_AOK  = 2'd0;
    localparam logic [3:0] ICODE_NOP = 4'h1;
    localparam logic [3:0] REG_NONE  = 4'hF;
    localparam int         NREGS     = 15;

    logic [1:0]       w_stat_q,  w_stat_d;
    logic [3:0]       w_icode_q, w_icode_d;
    logic [3:0]       w_dste_q,  w_dste_d;
    logic [3:0]       w_dstm_q,  w_dstm_d;
    logic [XLEN-1:0]  w_vale_q,  w_vale_d;
    logic [XLEN-1:0]  w_valm_q,  w_valm_d;
    logic             w_valid_q, w_valid_d;
    logic             halted_q,  halted_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [XLEN-1:0]  rf_q [NREGS];
    logic [XLEN-1:0]  rf_d [NREGS];
    logic             commit_en;

    // Once halted the W register freezes; stall outranks bubble.
    always_comb begin
        w_stat_d  = w_stat_q;
        w_icode_d = w_icode_q;
        w_dste_d  = w_dste_q;
        w_dstm_d  = w_dstm_q;
        w_vale_d  = w_vale_q;
        w_valm_d  = w_valm_q;
        w_valid_d = w_valid_q;
        if (!halted_q && !w_stall) begin
            if (w_bubble) begin
                w_stat_d  = STAT_AOK;
                w_icode_d = ICODE_NOP;
                w_dste_d  = REG_NONE;
                w_dstm_d  = REG_NONE;
                w_vale_d  = '0;
                w_valm_d  = '0;
                w_valid_d = 1'b0;
            end else begin
                w_stat_d  = m_stat;
                w_icode_d = m_icode;
                w_dste_d  = m_dstE;
                w_dstm_d  = m_dstM;
                w_vale_d  = m_valE;
                w_valm_d  = m_valM;
                w_valid_d = 1'b1;
            end
        end
    end

    // dstM is applied after dstE so valM wins on a shared destination (popq %rsp).
    always_comb begin
        commit_en = (w_stat_q == STAT_AOK) && !halted_q;
        for (int i = 0; i < NREGS; i++) begin
            rf_d[i] = rf_q[i];
            if (commit_en && (w_dste_q == 4'(i))) rf_d[i] = w_vale_q;
            if (commit_en && (w_dstm_q == 4'(i))) rf_d[i] = w_valm_q;
        end
    end

    always_comb begin
        halted_d  = halted_q | (w_stat_q != STAT_AOK);
        retired_d = retired_q;
        if (w_valid_q && (w_stat_q == STAT_AOK) && !halted_q && !w_stall
            && (retired_q != {CNT_W{1'b1}})) begin
            retired_d = retired_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_stat_q  <= STAT_AOK;
            w_icode_q <= ICODE_NOP;
            w_dste_q  <= REG_NONE;
            w_dstm_q  <= REG_NONE;
            w_vale_q  <= '0;
            w_valm_q  <= '0;
            w_valid_q <= 1'b0;
            halted_q  <= 1'b0;
            retired_q <= '0;
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= (i == 4) ? RSP_INIT : '0;
            end
        end else begin
            w_stat_q  <= w_stat_d;
            w_icode_q <= w_icode_d;
            w_dste_q  <= w_dste_d;
            w_dstm_q  <= w_dstm_d;
            w_vale_q  <= w_vale_d;
            w_valm_q  <= w_valm_d;
            w_valid_q <= w_valid_d;
            halted_q  <= halted_d;
            retired_q <= retired_d;
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= rf_d[i];
            end
        end
    end

    // Address 15 matches no entry, so it reads as zero.
    always_comb begin
        rvalA = '0;
        rvalB = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (srcA == 4'(i)) rvalA = rf_q[i];
            if (srcB == 4'(i)) rvalB = rf_q[i];
        end
    end

    assign W_stat  = w_stat_q;
    assign W_icode = w_icode_q;
    assign W_dstE  = w_dste_q;
    assign W_dstM  = w_dstm_q;
    assign W_valE  = w_vale_q;
    assign W_valM  = w_valm_q;
    assign halted  = halted_q;
    assign retired = retired_q;

endmodule
